// File: rtl/mc_control_unit.sv
// mc_control_unit: multi-cycle RV32I control FSM (IF/ID/EX/MEM/WB/TRAP/HALT).
// Drives datapath enables and mux selects as Moore decodes of the registered
// state and latched opcode. ir_write, pc_write and the IF exit follow
// mem_ready in the same cycle. IF and MEM waits are bounded by MEM_TIMEOUT,
// where 0 disables the bound. Also keeps cycle and retired-instruction counters.
//
// Build option: define ECALL_HALT_EN to make opcode 1110011 halt the FSM
// (retired). Without it, that opcode traps as illegal.
//
// Ports:
//   clk, reset (sync, active-low)
//   opcode[6:0], alu_bcond, mem_ready               inputs
//   pc_write, pc_write_cond, i_or_d, mem_read,
//   mem_write, ir_write, reg_write                  datapath enables
//   mem_to_reg, pc_to_reg, alu_src_a,
//   alu_src_b[1:0], pc_source[1:0], alu_op[1:0]     datapath selects
//   illegal, mem_fault (sticky), halted             status
//   cycle_cnt, retired_cnt [CNT_WIDTH-1:0]          performance counters
module mc_control_unit #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           opcode,
  input  logic                 alu_bcond,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 pc_write_cond,
  output logic                 i_or_d,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 reg_write,
  output logic                 mem_to_reg,
  output logic                 pc_to_reg,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           pc_source,
  output logic [1:0]           alu_op,
  output logic                 illegal,
  output logic                 mem_fault,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] cycle_cnt,
  output logic [CNT_WIDTH-1:0] retired_cnt
);

  localparam int unsigned WAIT_W  = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam int unsigned TO_LAST = (MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
`ifdef ECALL_HALT_EN
  localparam logic [6:0] OP_SYS   = 7'b1110011;
`endif

  typedef enum logic [2:0] {
    S_IF, S_ID, S_EX, S_MEM, S_WB, S_TRAP, S_HALT
  } state_e;

  state_e                 state_q, state_d;
  logic [6:0]             op_q, op_d;
  logic                   run_q, run_d;
  logic [WAIT_W-1:0]      wait_q, wait_d;
  logic                   illegal_q, illegal_d;
  logic                   fault_q, fault_d;
  logic [CNT_WIDTH-1:0]   cycle_q, cycle_d;
  logic [CNT_WIDTH-1:0]   retired_q, retired_d;
  logic                   retire_c;
  logic                   timeout_c;
  logic                   unused_bcond;

  // The branch decision is applied in the datapath through pc_write_cond.
  assign unused_bcond = alu_bcond;

  assign timeout_c = (MEM_TIMEOUT != 0) && (wait_q == WAIT_W'(TO_LAST));

  // State and counter registers; run_q keeps outputs quiet until the first edge after release.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IF;
      op_q      <= '0;
      run_q     <= 1'b0;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      fault_q   <= 1'b0;
      cycle_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      run_q     <= run_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      fault_q   <= fault_d;
      cycle_q   <= cycle_d;
      retired_q <= retired_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    run_d         = 1'b1;
    wait_d        = wait_q;
    illegal_d     = illegal_q;
    fault_d       = fault_q;
    retire_c      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    pc_to_reg     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_source     = 2'b00;
    alu_op        = 2'b00;

    if (run_q) begin
      case (state_q)
        S_IF: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
          if (mem_ready) begin
            state_d = S_ID;
          end else if (timeout_c) begin
            state_d = S_TRAP;
            fault_d = 1'b1;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
        S_ID: begin
          // Branch/jal target precomputed into ALUOut.
          alu_src_b = 2'b10;
          op_d      = opcode;
          case (opcode)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR, OP_JAL, OP_JALR: state_d = S_EX;
`ifdef ECALL_HALT_EN
            OP_SYS: begin
              state_d  = S_HALT;
              retire_c = 1'b1;
            end
`endif
            default: begin
              state_d   = S_TRAP;
              illegal_d = 1'b1;
            end
          endcase
        end
        S_EX: begin
          case (op_q)
            OP_R: begin
              alu_src_a = 1'b1;
              alu_op    = 2'b10;
              state_d   = S_WB;
            end
            OP_I: begin
              alu_src_a = 1'b1;
              alu_src_b = 2'b10;
              alu_op    = 2'b10;
              state_d   = S_WB;
            end
            OP_LOAD, OP_STORE: begin
              alu_src_a = 1'b1;
              alu_src_b = 2'b10;
              state_d   = S_MEM;
            end
            OP_BR: begin
              alu_src_a     = 1'b1;
              alu_op        = 2'b01;
              pc_write_cond = 1'b1;
              pc_source     = 2'b01;
              state_d       = S_IF;
              retire_c      = 1'b1;
            end
            OP_JAL: begin
              pc_source = 2'b01;
              state_d   = S_WB;
            end
            OP_JALR: begin
              alu_src_a = 1'b1;
              alu_src_b = 2'b10;
              pc_source = 2'b10;
              state_d   = S_WB;
            end
            default: begin
              state_d   = S_TRAP;
              illegal_d = 1'b1;
            end
          endcase
        end
        S_MEM: begin
          i_or_d    = 1'b1;
          mem_read  = (op_q == OP_LOAD);
          mem_write = (op_q == OP_STORE);
          if (mem_ready) begin
            if (op_q == OP_LOAD) begin
              state_d = S_WB;
            end else begin
              state_d  = S_IF;
              retire_c = 1'b1;
            end
          end else if (timeout_c) begin
            state_d = S_TRAP;
            fault_d = 1'b1;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
        S_WB: begin
          reg_write = 1'b1;
          if (op_q == OP_LOAD) begin
            mem_to_reg = 1'b1;
          end else if (op_q == OP_JAL || op_q == OP_JALR) begin
            pc_to_reg = 1'b1;
            pc_write  = 1'b1;
            pc_source = (op_q == OP_JAL) ? 2'b01 : 2'b10;
          end
          state_d  = S_IF;
          retire_c = 1'b1;
        end
        S_TRAP, S_HALT: ;
        default: state_d = S_TRAP;
      endcase
    end

    // Wait counter restarts on every state change so IF/MEM entries start at zero.
    if (state_d != state_q) wait_d = '0;

    cycle_d   = cycle_q + CNT_WIDTH'(run_q && state_q != S_TRAP && state_q != S_HALT);
    retired_d = retired_q + CNT_WIDTH'(retire_c);
  end

  assign illegal     = illegal_q;
  assign mem_fault   = fault_q;
  assign halted      = run_q && (state_q == S_HALT);
  assign cycle_cnt   = cycle_q;
  assign retired_cnt = retired_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Scoreboard bench for mc_control_unit (MEM_TIMEOUT=4, CNT_WIDTH=4 so wrap is reachable).
// Stimulus pushes the hand-computed output word for each cycle; the monitor
// pops and compares on the falling edge.
module tb_mc_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic       alu_bcond;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_write;
  logic       mem_to_reg, pc_to_reg, alu_src_a;
  logic [1:0] alu_src_b, pc_source, alu_op;
  logic       illegal, mem_fault, halted;
  logic [3:0] cycle_cnt, retired_cnt;

  always #5 clk = ~clk;

  mc_control_unit #(.MEM_TIMEOUT(4), .CNT_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .alu_bcond(alu_bcond), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .pc_to_reg(pc_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
    .alu_op(alu_op), .illegal(illegal), .mem_fault(mem_fault), .halted(halted),
    .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt)
  );

  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011, ST = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111;
  localparam logic [6:0] SYS = 7'b1110011, BAD = 7'b0000000;

  // pw pwc iod mr mw irw rw m2r p2r asa | alu_src_b pc_source alu_op
  localparam logic [15:0] C_ZERO    = 16'b0_0_0_0_0_0_0_0_0_0_00_00_00;
  localparam logic [15:0] C_IF_R    = 16'b1_0_0_1_0_1_0_0_0_0_01_00_00;
  localparam logic [15:0] C_IF_W    = 16'b0_0_0_1_0_0_0_0_0_0_01_00_00;
  localparam logic [15:0] C_ID      = 16'b0_0_0_0_0_0_0_0_0_0_10_00_00;
  localparam logic [15:0] C_EX_R    = 16'b0_0_0_0_0_0_0_0_0_1_00_00_10;
  localparam logic [15:0] C_EX_I    = 16'b0_0_0_0_0_0_0_0_0_1_10_00_10;
  localparam logic [15:0] C_EX_LS   = 16'b0_0_0_0_0_0_0_0_0_1_10_00_00;
  localparam logic [15:0] C_EX_BR   = 16'b0_1_0_0_0_0_0_0_0_1_00_01_01;
  localparam logic [15:0] C_EX_JAL  = 16'b0_0_0_0_0_0_0_0_0_0_00_01_00;
  localparam logic [15:0] C_EX_JALR = 16'b0_0_0_0_0_0_0_0_0_1_10_10_00;
  localparam logic [15:0] C_MEM_LD  = 16'b0_0_1_1_0_0_0_0_0_0_00_00_00;
  localparam logic [15:0] C_MEM_ST  = 16'b0_0_1_0_1_0_0_0_0_0_00_00_00;
  localparam logic [15:0] C_WB_ALU  = 16'b0_0_0_0_0_0_1_0_0_0_00_00_00;
  localparam logic [15:0] C_WB_LD   = 16'b0_0_0_0_0_0_1_1_0_0_00_00_00;
  localparam logic [15:0] C_WB_JAL  = 16'b1_0_0_0_0_0_1_0_1_0_00_01_00;
  localparam logic [15:0] C_WB_JALR = 16'b1_0_0_0_0_0_1_0_1_0_00_10_00;

  // flags: {illegal, mem_fault, halted}
  localparam logic [2:0] F_NONE = 3'b000, F_ILL = 3'b100, F_FLT = 3'b010, F_HLT = 3'b001;

  logic [26:0] exp_q[$];
  string       nm_q[$];
  int          checks = 0;
  int          errors = 0;

  // Drive one cycle's inputs and queue the outputs expected during that cycle.
  task automatic cyc(input logic rst_i, input logic [6:0] op_i, input logic rdy_i,
                     input logic bc_i, input logic [15:0] ctl, input logic [2:0] flg,
                     input int cy, input int rt, input string nm);
    @(posedge clk);
    #1;
    reset     = rst_i;
    opcode    = op_i;
    mem_ready = rdy_i;
    alu_bcond = bc_i;
    exp_q.push_back({ctl, flg, 4'(cy), 4'(rt)});
    nm_q.push_back(nm);
  endtask

  // Monitor: compare every queued expectation against the live outputs.
  initial begin
    logic [26:0] e, a;
    string       n;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n = nm_q.pop_front();
        a = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_write,
             mem_to_reg, pc_to_reg, alu_src_a, alu_src_b, pc_source, alu_op,
             illegal, mem_fault, halted, cycle_cnt, retired_cnt};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL %s: got ctl=%b flags=%b cyc=%0d ret=%0d, want ctl=%b flags=%b cyc=%0d ret=%0d",
                   n, a[26:11], a[10:8], a[7:4], a[3:0], e[26:11], e[10:8], e[7:4], e[3:0]);
        end
      end
    end
  end

  initial begin
    reset = 1'b0; opcode = '0; mem_ready = 1'b0; alu_bcond = 1'b0;

    cyc(0, BAD, 0, 0, C_ZERO, F_NONE, 0, 0, "rst_hold");
    cyc(1, BAD, 0, 0, C_ZERO, F_NONE, 0, 0, "rst_release");

    // R-type, zero-wait memory
    cyc(1, R, 1, 0, C_IF_R,   F_NONE, 0, 0, "r_if");
    cyc(1, R, 1, 0, C_ID,     F_NONE, 1, 0, "r_id");
    cyc(1, R, 1, 0, C_EX_R,   F_NONE, 2, 0, "r_ex");
    cyc(1, R, 1, 0, C_WB_ALU, F_NONE, 3, 0, "r_wb");
    // I-type
    cyc(1, I, 1, 0, C_IF_R,   F_NONE, 4, 1, "i_if");
    cyc(1, I, 1, 0, C_ID,     F_NONE, 5, 1, "i_id");
    cyc(1, I, 1, 0, C_EX_I,   F_NONE, 6, 1, "i_ex");
    cyc(1, I, 1, 0, C_WB_ALU, F_NONE, 7, 1, "i_wb");
    // Load, three wait cycles; ready on the last allowed cycle
    cyc(1, LD, 1, 0, C_IF_R,   F_NONE, 8,  2, "ld_if");
    cyc(1, LD, 1, 0, C_ID,     F_NONE, 9,  2, "ld_id");
    cyc(1, LD, 1, 0, C_EX_LS,  F_NONE, 10, 2, "ld_ex");
    cyc(1, LD, 0, 0, C_MEM_LD, F_NONE, 11, 2, "ld_mem_w0");
    cyc(1, LD, 0, 0, C_MEM_LD, F_NONE, 12, 2, "ld_mem_w1");
    cyc(1, LD, 0, 0, C_MEM_LD, F_NONE, 13, 2, "ld_mem_w2");
    cyc(1, LD, 1, 0, C_MEM_LD, F_NONE, 14, 2, "ld_mem_rdy");
    cyc(1, LD, 1, 0, C_WB_LD,  F_NONE, 15, 2, "ld_wb");
    // Store; cycle counter wraps 15 -> 0
    cyc(1, ST, 1, 0, C_IF_R,   F_NONE, 0, 3, "st_if_wrap");
    cyc(1, ST, 1, 0, C_ID,     F_NONE, 1, 3, "st_id");
    cyc(1, ST, 1, 0, C_EX_LS,  F_NONE, 2, 3, "st_ex");
    cyc(1, ST, 1, 0, C_MEM_ST, F_NONE, 3, 3, "st_mem");
    // Branch taken then not taken
    cyc(1, BR, 1, 1, C_IF_R,   F_NONE, 4, 4, "bt_if");
    cyc(1, BR, 1, 1, C_ID,     F_NONE, 5, 4, "bt_id");
    cyc(1, BR, 1, 1, C_EX_BR,  F_NONE, 6, 4, "bt_ex");
    cyc(1, BR, 1, 0, C_IF_R,   F_NONE, 7, 5, "bn_if");
    cyc(1, BR, 1, 0, C_ID,     F_NONE, 8, 5, "bn_id");
    cyc(1, BR, 1, 0, C_EX_BR,  F_NONE, 9, 5, "bn_ex");
    // jal / jalr
    cyc(1, JAL, 1, 0, C_IF_R,    F_NONE, 10, 6, "jal_if");
    cyc(1, JAL, 1, 0, C_ID,      F_NONE, 11, 6, "jal_id");
    cyc(1, JAL, 1, 0, C_EX_JAL,  F_NONE, 12, 6, "jal_ex");
    cyc(1, JAL, 1, 0, C_WB_JAL,  F_NONE, 13, 6, "jal_wb");
    cyc(1, JALR, 1, 0, C_IF_R,   F_NONE, 14, 7, "jalr_if");
    cyc(1, JALR, 1, 0, C_ID,     F_NONE, 15, 7, "jalr_id");
    cyc(1, JALR, 1, 0, C_EX_JALR, F_NONE, 0, 7, "jalr_ex");
    cyc(1, JALR, 1, 0, C_WB_JALR, F_NONE, 1, 7, "jalr_wb");
    // Illegal opcode traps after ID; counters freeze; reset clears
    cyc(1, BAD, 1, 0, C_IF_R, F_NONE, 2, 8, "ill_if");
    cyc(1, BAD, 1, 0, C_ID,   F_NONE, 3, 8, "ill_id");
    cyc(1, BAD, 1, 0, C_ZERO, F_ILL,  4, 8, "ill_trap");
    cyc(0, BAD, 1, 0, C_ZERO, F_ILL,  4, 8, "ill_trap_frozen");
    cyc(1, BAD, 0, 0, C_ZERO, F_NONE, 0, 0, "ill_rst");

    // IF timeout after 4 waiting cycles
    cyc(1, R, 0, 0, C_IF_W, F_NONE, 0, 0, "to_if0");
    cyc(1, R, 0, 0, C_IF_W, F_NONE, 1, 0, "to_if1");
    cyc(1, R, 0, 0, C_IF_W, F_NONE, 2, 0, "to_if2");
    cyc(1, R, 0, 0, C_IF_W, F_NONE, 3, 0, "to_if3");
    cyc(1, R, 0, 0, C_ZERO, F_FLT,  4, 0, "to_trap");
    cyc(0, R, 1, 0, C_ZERO, F_FLT,  4, 0, "to_trap_frozen");
    cyc(1, R, 0, 0, C_ZERO, F_NONE, 0, 0, "to_rst");

    // ecall
    cyc(1, SYS, 1, 0, C_IF_R, F_NONE, 0, 0, "ecall_if");
    cyc(1, SYS, 1, 0, C_ID,   F_NONE, 1, 0, "ecall_id");
`ifdef ECALL_HALT_EN
    cyc(1, SYS, 1, 0, C_ZERO, F_HLT,  2, 1, "ecall_halt");
    cyc(0, SYS, 1, 0, C_ZERO, F_HLT,  2, 1, "ecall_halt_frozen");
`else
    cyc(1, SYS, 1, 0, C_ZERO, F_ILL,  2, 0, "ecall_trap");
    cyc(0, SYS, 1, 0, C_ZERO, F_ILL,  2, 0, "ecall_trap_frozen");
`endif
    cyc(1, SYS, 0, 0, C_ZERO, F_NONE, 0, 0, "ecall_rst");

    // MEM timeout on a load
    cyc(1, LD, 1, 0, C_IF_R,   F_NONE, 0, 0, "mto_if");
    cyc(1, LD, 1, 0, C_ID,     F_NONE, 1, 0, "mto_id");
    cyc(1, LD, 0, 0, C_EX_LS,  F_NONE, 2, 0, "mto_ex");
    cyc(1, LD, 0, 0, C_MEM_LD, F_NONE, 3, 0, "mto_mem0");
    cyc(1, LD, 0, 0, C_MEM_LD, F_NONE, 4, 0, "mto_mem1");
    cyc(1, LD, 0, 0, C_MEM_LD, F_NONE, 5, 0, "mto_mem2");
    cyc(1, LD, 0, 0, C_MEM_LD, F_NONE, 6, 0, "mto_mem3");
    cyc(0, LD, 0, 0, C_ZERO,   F_FLT,  7, 0, "mto_trap");
    cyc(1, LD, 0, 0, C_ZERO,   F_NONE, 0, 0, "mto_rst");

    // Reset during store MEM aborts it
    cyc(1, ST, 1, 0, C_IF_R,   F_NONE, 0, 0, "sa_if");
    cyc(1, ST, 1, 0, C_ID,     F_NONE, 1, 0, "sa_id");
    cyc(1, ST, 0, 0, C_EX_LS,  F_NONE, 2, 0, "sa_ex");
    cyc(1, ST, 0, 0, C_MEM_ST, F_NONE, 3, 0, "sa_mem");
    cyc(0, ST, 0, 0, C_MEM_ST, F_NONE, 4, 0, "sa_mem_rst");
    cyc(0, ST, 0, 0, C_ZERO,   F_NONE, 0, 0, "sa_abort");
    cyc(1, ST, 0, 0, C_ZERO,   F_NONE, 0, 0, "sa_release");
    cyc(1, ST, 1, 0, C_IF_R,   F_NONE, 0, 0, "sa_if_after");

    // Let the monitor drain, bounded.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_control_unit.md
# mc_control_unit

Multi-cycle successor to the single-cycle control decoder: a Moore FSM that sequences each RV32I instruction through fetch, decode, execute, memory and write-back states, driving the multi-cycle datapath's enables and mux selects. Memory accesses use a ready handshake with a configurable timeout. The block also keeps cycle and retired-instruction counters. It sits between the instruction register (opcode source) and the shared datapath/memory of the multi-cycle CPU.

## Interface
- MEM_TIMEOUT, 16: max cycles in IF/MEM waiting for `mem_ready`; 0 disables the timeout
- CNT_WIDTH, 32: width of the cycle and retired counters
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  reset; synchronous, active-low
- opcode  in  7  instruction[6:0] from the instruction register; valid from ID onward
- alu_bcond  in  1  branch condition result from the ALU, sampled in EX
- mem_ready  in  1  memory completes the current access this cycle
- pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_write  out  1 each  datapath enables
- mem_to_reg, pc_to_reg, alu_src_a  out  1 each  datapath selects
- alu_src_b  out  2  00 reg, 01 const 4, 10 imm
- pc_source  out  2  00 ALU result, 01 ALUOut register, 10 ALUOut & ~1 (jalr)
- alu_op  out  2  00 add, 01 branch compare, 10 funct-decoded
- illegal, mem_fault  out  1 each  sticky trap flags
- halted  out  1  FSM is in HALT
- cycle_cnt, retired_cnt  out  CNT_WIDTH  performance counters

## Operation
- States: IF, ID, EX, MEM, WB, TRAP, HALT. Opcode latched into an internal register at the end of ID; EX/MEM/WB decode from the latched copy.
- IF: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00; ir_write=pc_write=mem_ready, pc_source=00. Stay in IF until mem_ready, then go to ID.
- ID: alu_src_a=0, alu_src_b=10, alu_op=00 (branch/jal target into ALUOut). Opcode 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111 → EX; any other → TRAP with illegal=1.
- EX: R-type alu_src_a=1, alu_src_b=00, alu_op=10 → WB. I-type alu_src_a=1, alu_src_b=10, alu_op=10 → WB. Load/store alu_src_a=1, alu_src_b=10, alu_op=00 → MEM. Branch alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01 → IF; the datapath writes PC only when alu_bcond=1. jal pc_source=01 and jalr (alu_src_a=1, alu_src_b=10, alu_op=00, pc_source=10) → WB.
- MEM: i_or_d=1; load mem_read=1, store mem_write=1. On mem_ready: load → WB, store → IF (instruction retired).
- WB: reg_write=1. Load mem_to_reg=1; jal/jalr pc_to_reg=1, pc_write=1; otherwise ALU result. Next state IF.
- Retirement: retired_cnt increments on leaving WB, on store leaving MEM, and on branch leaving EX. cycle_cnt increments every cycle outside reset, TRAP and HALT. Both counters wrap modulo 2^CNT_WIDTH.
- Timeout: a wait counter clears on entry to IF/MEM and counts each cycle without mem_ready. When it reaches MEM_TIMEOUT, the FSM goes to TRAP with mem_fault=1. mem_ready in that same cycle wins and no fault is raised.
- TRAP: all enables 0; only reset leaves it.

## Timing
- Reset (reset=0 at an edge): state=IF, all outputs 0 including counters and flags. The first IF outputs appear in the cycle after release. Reset asserted mid-instruction aborts it with no further writes.
- Outputs are registered-state decodes only; no combinational path from mem_ready to the next state's outputs. Exception: ir_write, pc_write and the IF-exit condition follow mem_ready in the same cycle.
- Minimum latency with zero-wait memory: branch 3, R/I/jal/jalr/store 4, load 5 cycles.

## Configuration
- ECALL_HALT_EN defined: opcode 1110011 in ID goes to HALT (halted=1, all enables 0, counters frozen), and that instruction counts as retired.
- ECALL_HALT_EN undefined: 1110011 is illegal and goes to TRAP.

## Test plan
- R-type 0110011, mem_ready always 1 → IF,ID,EX,WB, then IF. reg_write=1 only in WB. retired_cnt 0→1, cycle_cnt=4.
- Load 0000011, mem_ready low 3 cycles in MEM → MEM held 4 cycles, then WB with mem_to_reg=1. Total 8 cycles.
- Branch with alu_bcond=1, then with alu_bcond=0 → pc_write_cond=1 in EX both times, and the FSM returns to IF after 3 cycles each.
- MEM_TIMEOUT=4, mem_ready never asserted in IF → TRAP after 4 cycles with mem_fault=1 and cycle_cnt frozen. reset=0 then clears all of it.
- Opcode 0000000 → TRAP with illegal=1 after ID. With ECALL_HALT_EN defined, 1110011 → halted=1 and retired_cnt incremented.
- reset=0 during MEM of a store → mem_write drops to 0 the next cycle and state=IF after release.
